dm_bus_arbiter: RTL and testbench

- Shares one system-bus master port between two requesters:
  - port 0: hart data-side fetch/load/store;
  - port 1: debug module System Bus Access master (master_* of dm_top).
- Sits between dm_top and the SoC interconnect.
- Uses the codebase req/gnt/r_valid protocol with a single outstanding transaction.
- A response timeout keeps an unresponsive slave from hanging the debugger.

---
 rtl/dm_bus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_arbiter.sv
// dm_bus_arbiter: shares one req/gnt/r_valid system-bus master port between
// the hart data side (requester 0) and the debug SBA master (requester 1).
// Only one transaction is outstanding at a time. A response timeout returns a
// synthetic error and arms a late flag that swallows the stale response.
//
// Optional feature macro: DM_BUS_ARB_DEBUG_PRIO_EN
//   defined   -> fixed priority, debug SBA wins every tie
//   undefined -> round-robin on ties, based on the last granted requester
//
// Handshake: a requester holds req/we/addr/wdata/be stable until the cycle
// where its m_gnt_o bit is high. m_gnt_o is high only in a cycle where
// bus_req_o and bus_gnt_i are both high. m_r_valid_o is a one-cycle pulse and
// qualifies m_r_err_o and m_r_rdata_o.
`timescale 1ns/1ps

module dm_bus_arbiter #(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              m_req_i,
  input  logic [1:0]              m_we_i,
  input  logic [2*BusWidth-1:0]   m_addr_i,
  input  logic [2*BusWidth-1:0]   m_wdata_i,
  input  logic [2*BusWidth/8-1:0] m_be_i,
  output logic [1:0]              m_gnt_o,
  output logic [1:0]              m_r_valid_o,
  output logic [1:0]              m_r_err_o,
  output logic [BusWidth-1:0]     m_r_rdata_o,
  output logic                    bus_req_o,
  output logic                    bus_we_o,
  output logic [BusWidth-1:0]     bus_addr_o,
  output logic [BusWidth-1:0]     bus_wdata_o,
  output logic [BusWidth/8-1:0]   bus_be_o,
  input  logic                    bus_gnt_i,
  input  logic                    bus_r_valid_i,
  input  logic                    bus_r_err_i,
  input  logic [BusWidth-1:0]     bus_r_rdata_i,
  output logic                    owner_o,
  output logic [1:0]              dbg_state_o
);

  localparam int BeW     = BusWidth / 8;
  localparam int CntW    = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam int LastInt = (TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0;
  localparam logic [CntW-1:0] CntLast = LastInt[CntW-1:0];
  localparam logic [CntW-1:0] CntOne  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_owner;
  logic            r_last_grant;
  logic            r_late;
  logic [CntW-1:0] r_cnt;

  logic            w_any_req;
  logic            w_winner;
  logic            w_owner_req;
  logic            w_grant;
  logic            w_resp;
  logic            w_timeout;
  logic            w_absorb;
  logic            w_owner_we;
  logic [BusWidth-1:0] w_owner_addr;
  logic [BusWidth-1:0] w_owner_wdata;
  logic [BeW-1:0]      w_owner_be;

  assign w_any_req     = |m_req_i;
  assign w_owner_req   = m_req_i[r_owner];
  assign w_owner_we    = m_we_i[r_owner];
  assign w_owner_addr  = r_owner ? m_addr_i[2*BusWidth-1:BusWidth]  : m_addr_i[BusWidth-1:0];
  assign w_owner_wdata = r_owner ? m_wdata_i[2*BusWidth-1:BusWidth] : m_wdata_i[BusWidth-1:0];
  assign w_owner_be    = r_owner ? m_be_i[2*BeW-1:BeW]              : m_be_i[BeW-1:0];

  // A grant needs the owner to still be requesting; a dropped req never gets one.
  assign w_grant   = (r_state == ST_ADDR) && w_owner_req && bus_gnt_i;
  assign w_resp    = (r_state == ST_RESP) && bus_r_valid_i;
  // A real response in the expiry cycle takes precedence over the timeout.
  assign w_timeout = (TimeoutCycles != 0) && (r_state == ST_RESP) &&
                     !bus_r_valid_i && (r_cnt == CntLast);
  assign w_absorb  = r_late && bus_r_valid_i;

  assign owner_o     = r_owner;
  assign dbg_state_o = r_state;

  // Arbitration between the two requesters when leaving IDLE.
  always_comb begin
    w_winner = 1'b0;
`ifdef DM_BUS_ARB_DEBUG_PRIO_EN
    w_winner = m_req_i[1];
`else
    if (m_req_i == 2'b11) begin
      w_winner = ~r_last_grant;
    end else begin
      w_winner = m_req_i[1];
    end
`endif
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; IDLE waits out a pending late response before arbitrating.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req && !r_late)  w_state_nxt = ST_ADDR;
      ST_ADDR: if (w_grant)               w_state_nxt = ST_RESP;
      ST_RESP: if (w_resp || w_timeout)   w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  // Owner, round-robin history, timeout counter and late-response flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_late       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_any_req && !r_late) begin
        r_owner <= w_winner;
      end
      if (w_grant) begin
        r_last_grant <= r_owner;
      end
      if (w_grant) begin
        r_cnt <= '0;
      end else if ((r_state == ST_RESP) && !bus_r_valid_i) begin
        r_cnt <= r_cnt + CntOne;
      end
      if (w_timeout) begin
        r_late <= 1'b1;
      end else if (w_absorb) begin
        r_late <= 1'b0;
      end
    end
  end

  // Output decode: bus side driven only in ADDR, responses only in RESP.
  always_comb begin
    m_gnt_o     = 2'b00;
    m_r_valid_o = 2'b00;
    m_r_err_o   = 2'b00;
    m_r_rdata_o = '0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    bus_be_o    = '0;
    case (r_state)
      ST_ADDR: begin
        bus_req_o          = w_owner_req;
        bus_we_o           = w_owner_we;
        bus_addr_o         = w_owner_addr;
        bus_wdata_o        = w_owner_wdata;
        bus_be_o           = w_owner_be;
        m_gnt_o[r_owner]   = w_grant;
      end
      ST_RESP: begin
        if (bus_r_valid_i) begin
          m_r_valid_o[r_owner] = 1'b1;
          m_r_err_o[r_owner]   = bus_r_err_i;
          m_r_rdata_o          = bus_r_rdata_i;
        end else if (w_timeout) begin
          m_r_valid_o[r_owner] = 1'b1;
          m_r_err_o[r_owner]   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// tb_dm_bus_arbiter: randomized and directed bench for dm_bus_arbiter built
// with TimeoutCycles = 8. The reference model works at transaction level:
// it picks the winner from the tie rule, predicts the grant cycle from the
// slave's grant delay, and predicts a real or synthetic response from the
// slave's response delay against the timeout window.
`timescale 1ns/1ps

module tb_dm_bus_arbiter;

  localparam int BW = 32;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      m_req_i = '0;
  logic [1:0]      m_gnt_o, m_r_valid_o, m_r_err_o;
  logic [BW-1:0]   m_r_rdata_o;
  logic            bus_req_o, bus_we_o;
  logic [BW-1:0]   bus_addr_o, bus_wdata_o;
  logic [BW/8-1:0] bus_be_o;
  logic            bus_gnt_i = 1'b0;
  logic            bus_r_valid_i = 1'b0;
  logic            bus_r_err_i = 1'b0;
  logic [BW-1:0]   bus_r_rdata_i = '0;
  logic            owner_o;
  logic [1:0]      dbg_state_o;

  logic [BW-1:0]   p_addr  [2];
  logic [BW-1:0]   p_wdata [2];
  logic [BW/8-1:0] p_be    [2];
  logic            p_we    [2];

  dm_bus_arbiter #(.BusWidth(BW), .TimeoutCycles(TO)) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .m_req_i       (m_req_i),
    .m_we_i        ({p_we[1], p_we[0]}),
    .m_addr_i      ({p_addr[1], p_addr[0]}),
    .m_wdata_i     ({p_wdata[1], p_wdata[0]}),
    .m_be_i        ({p_be[1], p_be[0]}),
    .m_gnt_o       (m_gnt_o),
    .m_r_valid_o   (m_r_valid_o),
    .m_r_err_o     (m_r_err_o),
    .m_r_rdata_o   (m_r_rdata_o),
    .bus_req_o     (bus_req_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_be_o      (bus_be_o),
    .bus_gnt_i     (bus_gnt_i),
    .bus_r_valid_i (bus_r_valid_i),
    .bus_r_err_i   (bus_r_err_i),
    .bus_r_rdata_i (bus_r_rdata_i),
    .owner_o       (owner_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [BW:0] exp_q[$];   // {err, rdata} of each expected response

  task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic mdl_last = 1'b1;   // requester granted most recently

  function automatic logic mdl_pick(input logic [1:0] req);
    if (req == 2'b11) begin
`ifdef DM_BUS_ARB_DEBUG_PRIO_EN
      return 1'b1;
`else
      return ~mdl_last;
`endif
    end
    return req[1];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_port(input int k, input logic we, input logic [BW-1:0] addr,
                          input logic [BW-1:0] wdata, input logic [BW/8-1:0] be);
    p_we[k] = we; p_addr[k] = addr; p_wdata[k] = wdata; p_be[k] = be;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    m_req_i = 2'b00; bus_gnt_i = 1'b0; bus_r_valid_i = 1'b0; bus_r_err_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    mdl_last = 1'b1;
  endtask

  // One transaction: cycle 0 is IDLE arbitration, then gnt_dly ADDR cycles
  // without grant, the grant cycle, then RESP until a response or timeout.
  task automatic do_txn(input logic [1:0] req_new, input int gnt_dly, input int rsp_dly,
                        input int drop_cyc, input logic err, input logic [BW-1:0] rdata,
                        output logic got_w, output int late_left);
    logic       w;
    logic [1:0] e_gnt;
    logic [BW:0] e_rsp;
    got_w = 1'b0;
    late_left = 0;
    @(negedge clk);
    m_req_i = m_req_i | req_new;
    bus_gnt_i = 1'b0; bus_r_valid_i = 1'b0;
    #1;
    w = mdl_pick(m_req_i);
    check_eq("idle_bus_req", {31'd0, bus_req_o}, 32'd0);
    check_eq("idle_gnt", {30'd0, m_gnt_o}, 32'd0);
    for (int c = 0; c <= gnt_dly; c++) begin
      @(negedge clk);
      bus_gnt_i  = (c == gnt_dly) || (c == drop_cyc);
      m_req_i[w] = (c != drop_cyc);
      #1;
      e_gnt = (c == gnt_dly) ? (2'b01 << w) : 2'b00;
      check_eq("addr_owner", {31'd0, owner_o}, {31'd0, w});
      check_eq("addr_bus_req", {31'd0, bus_req_o}, {31'd0, (c != drop_cyc)});
      check_eq("addr_gnt", {30'd0, m_gnt_o}, {30'd0, e_gnt});
      if (c != drop_cyc) begin
        check_eq("addr_addr", bus_addr_o, p_addr[w]);
        check_eq("addr_wdata", bus_wdata_o, p_wdata[w]);
        check_eq("addr_be", {28'd0, bus_be_o}, {28'd0, p_be[w]});
        check_eq("addr_we", {31'd0, bus_we_o}, {31'd0, p_we[w]});
      end
      if (c == gnt_dly) got_w = m_gnt_o[1];
    end
    mdl_last = w;
    for (int i = 0; i <= rsp_dly; i++) begin
      @(negedge clk);
      m_req_i[w] = 1'b0;
      bus_gnt_i = 1'b0;
      bus_r_valid_i = (i == rsp_dly);
      bus_r_err_i = err;
      bus_r_rdata_i = (i == rsp_dly) ? rdata : $urandom;
      #1;
      check_eq("resp_gnt", {30'd0, m_gnt_o}, 32'd0);
      if (i == rsp_dly || i == TO - 1) begin
        if (i == rsp_dly) exp_q.push_back({err, rdata});
        else              exp_q.push_back({1'b1, {BW{1'b0}}});
        e_rsp = exp_q.pop_front();
        check_eq("resp_valid", {30'd0, m_r_valid_o}, {30'd0, (2'b01 << w)});
        check_eq("resp_err", {30'd0, m_r_err_o}, {30'd0, (e_rsp[BW] ? (2'b01 << w) : 2'b00)});
        check_eq("resp_rdata", m_r_rdata_o, e_rsp[BW-1:0]);
        if (i != rsp_dly) late_left = rsp_dly - i;
        break;
      end else begin
        check_eq("resp_wait_valid", {30'd0, m_r_valid_o}, 32'd0);
        check_eq("resp_wait_rdata", m_r_rdata_o, 32'd0);
      end
    end
  endtask

  // After a timeout: n IDLE cycles, the late response arriving on the last one.
  task automatic late_wait(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      bus_r_valid_i = (k == n);
      bus_r_err_i = 1'b0;
      bus_r_rdata_i = $urandom;
      #1;
      check_eq("late_valid", {30'd0, m_r_valid_o}, 32'd0);
      check_eq("late_gnt", {30'd0, m_gnt_o}, 32'd0);
      check_eq("late_bus_req", {31'd0, bus_req_o}, 32'd0);
    end
  endtask

  task automatic rand_txn();
    logic [1:0] nw;
    int gd, rd, dc, ll;
    logic gw;
    nw = 2'($urandom_range(0, 3));
    if ((m_req_i | nw) == 2'b00) nw = 2'b01;
    for (int k = 0; k < 2; k++)
      if (nw[k] && !m_req_i[k])
        set_port(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    gd = $urandom_range(0, 3);
    rd = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 4);
    dc = (gd > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, gd - 1) : -1;
    do_txn(nw, gd, rd, dc, 1'($urandom_range(0, 1)), $urandom, gw, ll);
    if (ll > 0) late_wait(ll);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic gw;
    int   ll;
    for (int k = 0; k < 2; k++) set_port(k, 1'b0, '0, '0, '0);
    do_reset();
    // reset state with live-looking inputs on the port side
    @(negedge clk);
    rst_ni = 1'b0;
    set_port(1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF);
    #1;
    check_eq("rst_gnt", {30'd0, m_gnt_o}, 32'd0);
    check_eq("rst_valid", {30'd0, m_r_valid_o}, 32'd0);
    check_eq("rst_bus_req", {31'd0, bus_req_o}, 32'd0);
    check_eq("rst_bus_addr", bus_addr_o, 32'd0);
    check_eq("rst_owner", {31'd0, owner_o}, 32'd0);
    do_reset();

    // hart-only read
    set_port(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF);
    do_txn(2'b01, 0, 2, -1, 1'b0, 32'hDEAD_BEEF, gw, ll);

    // both request continuously from a fresh reset
    do_reset();
    set_port(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    set_port(1, 1'b1, 32'h0000_0200, 32'hCAFE_0001, 4'h3);
    for (int t = 0; t < 4; t++) begin
      do_txn(2'b11, $urandom_range(0, 2), $urandom_range(0, 3), -1, 1'b0, $urandom, gw, ll);
`ifdef DM_BUS_ARB_DEBUG_PRIO_EN
      check_eq("tie_winner", {31'd0, gw}, 32'd1);
`else
      check_eq("tie_winner", {31'd0, gw}, t % 2);
`endif
    end
    do_txn(2'b00, 0, 0, -1, 1'b0, $urandom, gw, ll);   // drain held loser

    // debug write with grant delayed 5 cycles
    set_port(1, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF);
    do_txn(2'b10, 5, 1, -1, 1'b0, 32'h0, gw, ll);

    // timeout, late response 4 cycles after expiry, hart waiting meanwhile
    set_port(0, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
    do_txn(2'b01, 0, TO - 1 + 4, -1, 1'b0, 32'h0, gw, ll);
    check_eq("late_left", ll, 32'd4);
    set_port(0, 1'b1, 32'h0000_3000, 32'h5555_AAAA, 4'h1);
    m_req_i[0] = 1'b1;
    late_wait(ll);
    do_txn(2'b00, 0, 0, -1, 1'b0, 32'h0BAD_F00D, gw, ll);

    // response that coincides with the expiry cycle wins
    do_txn(2'b10, 0, TO - 1, -1, 1'b0, 32'h7777_0007, gw, ll);
    check_eq("coincide_no_late", ll, 32'd0);

    // slave error response
    do_txn(2'b01, 1, 2, -1, 1'b1, 32'h0000_0E00, gw, ll);

    // protocol violation: owner drops req while slave offers a grant
    do_txn(2'b10, 3, 1, 1, 1'b0, 32'h1111_2222, gw, ll);

    // reset during RESP with debug owning the bus
    set_port(1, 1'b1, 32'h0000_4000, 32'h4444_4444, 4'hF);
    @(negedge clk); m_req_i = 2'b10;
    @(negedge clk); bus_gnt_i = 1'b1;
    @(negedge clk); bus_gnt_i = 1'b0; m_req_i = 2'b00;
    @(negedge clk); rst_ni = 1'b0;
    #1;
    check_eq("rstresp_gnt", {30'd0, m_gnt_o}, 32'd0);
    check_eq("rstresp_valid", {30'd0, m_r_valid_o}, 32'd0);
    check_eq("rstresp_err", {30'd0, m_r_err_o}, 32'd0);
    check_eq("rstresp_rdata", m_r_rdata_o, 32'd0);
    check_eq("rstresp_bus_req", {31'd0, bus_req_o}, 32'd0);
    check_eq("rstresp_owner", {31'd0, owner_o}, 32'd0);
    @(negedge clk); rst_ni = 1'b1; mdl_last = 1'b1;
    @(negedge clk);
    bus_r_valid_i = 1'b1; bus_r_rdata_i = 32'h9999_9999;
    #1;
    check_eq("stray_rsp_dropped", {30'd0, m_r_valid_o}, 32'd0);
    check_eq("stray_rdata", m_r_rdata_o, 32'd0);
    set_port(0, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
    do_txn(2'b01, 0, 1, -1, 1'b0, 32'h5A5A_5A5A, gw, ll);

    // randomized traffic
    for (int t = 0; t < 60; t++) rand_txn();
    while (m_req_i != 2'b00) rand_txn();

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL exp_q_empty: got %0d entries expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
